maxpool_out_packer: RTL and testbench
=====================================

Name: maxpool_out_packer

Overview:
- Downstream of the per-channel maxpool units.
- Accepts the serial stream of pooled DATA_WIDTH words and packs PACK consecutive words into one wide output beat.
- Output is an AXI-Stream style handshake with backpressure, tkeep and tlast.
- Sits between the maxpool stage and the output DMA/width converter.

Parameters:
- DATA_WIDTH, 16: width of one pooled word.
- CONV_UNITS, 8: convolution units per core.
- PACK, CONV_UNITS/2: words per output beat, as a localparam. Must be ≥2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  input word valid.
- s_ready  out  1  packer can accept a word this cycle.
- s_data  in  DATA_WIDTH  pooled word, two's complement.
- s_last  in  1  word is the last of a row; forces a flush.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream accepts the beat.
- m_tdata  out  DATA_WIDTH*PACK  packed beat; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_tkeep  out  PACK  per-lane valid, one bit per word.
- m_tlast  out  1  beat closes a row.

Behaviour:
- Reset (async, rst=1), all effective immediately:
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
  - Lane counter cnt=0; assembly register cleared.
  - s_ready=1 once rst is deasserted.
  - Reset mid-row discards any partial beat; nothing is flushed.
- Input transfer: occurs when s_valid & s_ready.
  - The word is written to assembly lane cnt. First word goes to lane 0 (LSBs).
  - cnt increments on each transfer.
- Beat completion: a transfer completes a beat when cnt==PACK-1 or s_last=1.
  - The completed beat (assembly contents plus the current word) moves to the output register on the same clock edge.
  - m_tkeep has bits 0..cnt set.
  - m_tlast = s_last.
  - cnt returns to 0; assembly lanes clear to 0, so unused lanes output 0.
- Output register:
  - Holds m_tdata/m_tkeep/m_tlast stable while m_tvalid & !m_tready.
  - Cleared (m_tvalid=0) on m_tvalid & m_tready unless a new beat loads on the same edge.
- s_ready rule:
  - s_ready = !(m_tvalid & !m_tready & completing), where completing = (cnt==PACK-1) | s_last.
  - Non-completing words are always accepted, even while the output is stalled.
  - The combinational path m_tready→s_ready is intentional and must stay a single gate level.
- Simultaneous drain and load: beat N is accepted downstream and beat N+1 loads on the same edge. m_tvalid stays 1 with no bubble.
- s_last with cnt==PACK-1 produces one full beat: tkeep all 1s, tlast=1.
- s_last on the first word produces a 1-lane beat: tkeep=…0001.
- Latency: the word that completes a beat appears on m_tdata 1 cycle after its transfer edge.
- Throughput: one word per cycle sustained with m_tready=1.
- No data transformation in the base build: words pass bit-exact.
- s_valid=0 holds all state; there is no timeout flush.

Optional Feature:
- Macro MAXPOOL_PACK_RELU_EN.
- Defined: every word is clamped before lane write; if s_data MSB=1 the lane stores 0. This matches the sel=3 zero-compare ReLU path, which the pool stage leaves unused.
- Undefined: words stored unmodified; no clamp logic is synthesised.
- Handshake and latency are identical either way.

Decomposition:
- Shared package maxpool_pkg holds:
  - DATA_WIDTH and CONV_UNITS defaults;
  - the PACK derivation function;
  - the lane-slice helper function.
- One sub-module, pack_out_reg: the output holding register with its valid/ready logic.
- Lane counter and assembly stay in the top.

Test Plan (DATA_WIDTH=16, PACK=4):
- Stream 0x0001..0x0008, no s_last, m_tready=1 → two beats: 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005; tkeep=4'hF, tlast=0; 1-cycle latency.
- Words 0x00A0, 0x00A1 with s_last on the second → one beat 0x0000_0000_00A1_00A0; tkeep=4'h3, tlast=1.
- m_tready=0 for 10 cycles while 9 words are offered:
  - First beat is held stable.
  - 3 words are absorbed, then s_ready=0 on the completing 8th word.
  - Raise m_tready → both beats emitted in order, with no loss or duplication.
- Random m_tready (50%), 1000 random words with s_last every 7 → scoreboard matches tdata/tkeep/tlast exactly.
- Assert rst after 2 words of a beat → outputs zero immediately; next 4 words form a clean full beat.
- With MAXPOOL_PACK_RELU_EN: inputs 0xFFFE, 0x0005, 0x8000, 0x7FFF → beat 0x7FFF_0000_0005_0000.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared defaults and helpers for the maxpool output packer.
// Optional ReLU clamp is controlled by MAXPOOL_PACK_RELU_EN (see maxpool_out_packer).
package maxpool_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 16;
    localparam int unsigned CONV_UNITS_DEFAULT = 8;

    // Words per output beat: one beat carries half a core's convolution units.
    function automatic int unsigned pack_words(input int unsigned conv_units);
        return conv_units / 2;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output holding register for the packer: AXI-Stream style valid/ready with
// tkeep/tlast, loaded with a completed beat and cleared once accepted.
module pack_out_reg #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned KEEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic [KEEP_BITS-1:0] load_keep,
    input  logic                 load_last,
    input  logic                 m_tready,
    output logic                 m_tvalid,
    output logic [DATA_BITS-1:0] m_tdata,
    output logic [KEEP_BITS-1:0] m_tkeep,
    output logic                 m_tlast
);

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [KEEP_BITS-1:0] keep_q, keep_d;
    logic                 last_q, last_d;

    // The producer never loads while the register is stalled, so a load
    // always wins over the drain and gives back-to-back beats without a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load_en) begin
            valid_d = 1'b1;
            data_d  = load_data;
            keep_d  = load_keep;
            last_d  = load_last;
        end else if (valid_q && m_tready) begin
            valid_d = 1'b0;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign m_tvalid = valid_q;
    assign m_tdata  = data_q;
    assign m_tkeep  = keep_q;
    assign m_tlast  = last_q;

endmodule

// File: rtl/maxpool_out_packer.sv
// Packs PACK consecutive pooled words into one AXI-Stream beat with tkeep/tlast.
// Define MAXPOOL_PACK_RELU_EN to clamp negative words to zero before packing.
module maxpool_out_packer
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned CONV_UNITS = CONV_UNITS_DEFAULT
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            s_valid,
    output logic                                            s_ready,
    input  logic [DATA_WIDTH-1:0]                           s_data,
    input  logic                                            s_last,
    output logic                                            m_tvalid,
    input  logic                                            m_tready,
    output logic [DATA_WIDTH*pack_words(CONV_UNITS)-1:0]    m_tdata,
    output logic [pack_words(CONV_UNITS)-1:0]               m_tkeep,
    output logic                                            m_tlast
);

    localparam int unsigned PACK = pack_words(CONV_UNITS);
    localparam int unsigned CW   = $clog2(PACK);
    localparam int unsigned BW   = DATA_WIDTH * PACK;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         asm_q, asm_d;
    logic [DATA_WIDTH-1:0] word;
    logic [BW-1:0]         beat_data;
    logic [PACK-1:0]       beat_keep;
    logic                  completing;
    logic                  xfer;
    logic                  load_en;

`ifdef MAXPOOL_PACK_RELU_EN
    assign word = s_data[DATA_WIDTH-1] ? '0 : s_data;
`else
    assign word = s_data;
`endif

    assign completing = (cnt_q == CW'(PACK - 1)) || s_last;

    // Only a completing word needs the output register free, so the
    // m_tready -> s_ready path stays one gate deep.
    assign s_ready = !(m_tvalid && !m_tready && completing);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        beat_data = asm_q;
        beat_keep = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (CW'(i) == cnt_q) begin
                beat_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = word;
            end
            beat_keep[i] = (CW'(i) <= cnt_q);
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        load_en = 1'b0;
        if (xfer) begin
            if (completing) begin
                load_en = 1'b1;
                cnt_d   = '0;
                asm_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                asm_d   = beat_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

    pack_out_reg #(
        .DATA_BITS (BW),
        .KEEP_BITS (PACK)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_data (beat_data),
        .load_keep (beat_keep),
        .load_last (s_last),
        .m_tready  (m_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast)
    );

endmodule

// File: tb/tb_maxpool_out_packer.sv
// Self-checking bench for maxpool_out_packer (DATA_WIDTH=16, PACK=4).
module tb_maxpool_out_packer;

    localparam int DW = 16;
    localparam int PK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_tvalid;
    logic          m_tready;
    logic [63:0]   m_tdata;
    logic [3:0]    m_tkeep;
    logic          m_tlast;

    always #5 clk = ~clk;

    maxpool_out_packer #(
        .DATA_WIDTH (16),
        .CONV_UNITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int          n;
        logic [63:0] words;
        logic        last;
        logic [63:0] exp_data;
        logic [3:0]  exp_keep;
        logic        exp_last;
    } vec_t;

    beat_t       sb[$];
    vec_t        tbl[6];
    int          checks = 0;
    int          errors = 0;
    bit          use_model;
    bit          rand_tready;
    logic [15:0] mlane[4];
    int          mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon();
        beat_t e;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data %h keep %h last %b expected no beat",
                         m_tdata, m_tkeep, m_tlast);
            end else begin
                e = sb.pop_front();
                if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
                    errors++;
                    $display("FAIL beat: got data %h keep %h last %b expected data %h keep %h last %b",
                             m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < PK; j++) mlane[j] = '0;
        mcnt = 0;
    endtask

    task automatic model_accept(input logic [15:0] d, input logic l);
        beat_t       b;
        logic [15:0] v;
        v = d;
`ifdef MAXPOOL_PACK_RELU_EN
        if (v[15]) v = '0;
`endif
        mlane[mcnt] = v;
        if (mcnt == PK - 1 || l) begin
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < PK; j++) begin
                if (j <= mcnt) begin
                    b.data[j*DW +: DW] = mlane[j];
                    b.keep[j] = 1'b1;
                end
            end
            b.last = l;
            if (use_model) sb.push_back(b);
            model_reset();
        end else begin
            mcnt++;
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic send_word(input logic [15:0] d, input logic l, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!done && waited < 50) begin
            if (rand_tready) m_tready = 1'($urandom_range(0, 1));
            to_neg();
            waited++;
            if (s_ready === 1'b1) begin
                model_accept(d, l);
                done = 1'b1;
            end
            to_pos();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_ready in %0d cycles expected acceptance", waited);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        m_tready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            to_neg();
            to_pos();
            n++;
        end
        chk({name, "_drained"}, 64'(sb.size()), 64'd0);
        chk({name, "_idle_valid"}, 64'(m_tvalid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    w;
        time   t0;
        beat_t b;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_tready = 1'b1;
        use_model = 1'b0; rand_tready = 1'b0;
        model_reset();

        #3;
        chk("reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_tdata",  m_tdata,       64'd0);
        chk("reset_tkeep",  64'(m_tkeep),  64'd0);
        chk("reset_tlast",  64'(m_tlast),  64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        to_neg();
        chk("post_reset_sready", 64'(s_ready), 64'd1);
        to_pos();

        tbl[0] = '{4, 64'h0004_0003_0002_0001, 1'b0, 64'h0004_0003_0002_0001, 4'hF, 1'b0};
        tbl[1] = '{4, 64'h0008_0007_0006_0005, 1'b0, 64'h0008_0007_0006_0005, 4'hF, 1'b0};
        tbl[2] = '{2, 64'h0000_0000_00A1_00A0, 1'b1, 64'h0000_0000_00A1_00A0, 4'h3, 1'b1};
        tbl[3] = '{1, 64'hDEAD_BEEF_CAFE_1234, 1'b1, 64'h0000_0000_0000_1234, 4'h1, 1'b1};
        tbl[4] = '{4, 64'h4444_3333_2222_1111, 1'b1, 64'h4444_3333_2222_1111, 4'hF, 1'b1};
        tbl[5] = '{3, 64'h5555_0100_0001_7FFF, 1'b1, 64'h0000_0100_0001_7FFF, 4'h7, 1'b1};

        t0 = $time;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                send_word(tbl[i].words[k*DW +: DW], tbl[i].last && (k == tbl[i].n - 1), w);
            end
            b.data = tbl[i].exp_data;
            b.keep = tbl[i].exp_keep;
            b.last = tbl[i].exp_last;
            sb.push_back(b);
            chk("latency_valid", 64'(m_tvalid), 64'd1);
            if (i == 1) chk("throughput_8_words", 64'($time - t0), 64'd80);
        end
        drain("table");

`ifdef MAXPOOL_PACK_RELU_EN
        send_word(16'hFFFE, 1'b0, w);
        send_word(16'h0005, 1'b0, w);
        send_word(16'h8000, 1'b0, w);
        send_word(16'h7FFF, 1'b0, w);
        b.data = 64'h7FFF_0000_0005_0000;
        b.keep = 4'hF;
        b.last = 1'b0;
        sb.push_back(b);
        drain("relu");
`endif

        // Backpressure: first beat held, three words absorbed, completing word stalls
        use_model = 1'b1;
        m_tready  = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(16'(k), 1'b0, w);
        chk("stall_loaded_valid", 64'(m_tvalid), 64'd1);
        for (int k = 5; k <= 7; k++) begin
            send_word(16'(k), 1'b0, w);
            chk("stall_absorb_cycles", 64'(w), 64'd1);
            chk("stall_hold_data", m_tdata, 64'h0004_0003_0002_0001);
        end
        s_valid = 1'b1; s_data = 16'd8; s_last = 1'b0;
        repeat (3) begin
            to_neg();
            chk("stall_sready_low", 64'(s_ready), 64'd0);
            chk("stall_hold_data", m_tdata, 64'h0004_0003_0002_0001);
            chk("stall_hold_keep", 64'(m_tkeep), 64'hF);
            to_pos();
        end
        m_tready = 1'b1;
        to_neg();
        chk("release_sready", 64'(s_ready), 64'd1);
        model_accept(16'd8, 1'b0);
        to_pos();
        s_valid = 1'b0;
        chk("no_bubble_valid", 64'(m_tvalid), 64'd1);
        chk("no_bubble_data", m_tdata, 64'h0008_0007_0006_0005);
        send_word(16'd9, 1'b1, w);
        drain("stall");

        rand_tready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send_word(16'($urandom), (i % 7 == 6) || (i == 999), w);
        end
        rand_tready = 1'b0;
        drain("random");

        // Reset with a held beat and a partial row in flight
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++) send_word(16'(16'h0010 + k), 1'b0, w);
        send_word(16'h0020, 1'b0, w);
        send_word(16'h0021, 1'b0, w);
        #2;
        rst = 1'b1;
        #1;
        chk("midrow_reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrow_reset_tdata",  m_tdata,       64'd0);
        chk("midrow_reset_tkeep",  64'(m_tkeep),  64'd0);
        chk("midrow_reset_tlast",  64'(m_tlast),  64'd0);
        sb.delete();
        model_reset();
        to_pos();
        rst = 1'b0;
        to_neg();
        chk("midrow_reset_sready", 64'(s_ready), 64'd1);
        to_pos();
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) send_word(16'(16'h0030 + k), 1'b0, w);
        chk("post_reset_beat", m_tdata, 64'h0033_0032_0031_0030);
        chk("post_reset_keep", 64'(m_tkeep), 64'hF);
        drain("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
